// File: rtl/vx_launch_pkg.sv
// Shared definitions for the Vortex launch sequencer: controller states and the buffered DCR
// write entry.
`ifndef VX_DCR_ADDR_WIDTH
`define VX_DCR_ADDR_WIDTH 12
`endif
`ifndef VX_DCR_DATA_WIDTH
`define VX_DCR_DATA_WIDTH 32
`endif

package vx_launch_pkg;

  localparam int unsigned DcrAddrW = `VX_DCR_ADDR_WIDTH;
  localparam int unsigned DcrDataW = `VX_DCR_DATA_WIDTH;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCfg   = 3'd1;
  localparam logic [2:0] StHold  = 3'd2;
  localparam logic [2:0] StWaitb = 3'd3;
  localparam logic [2:0] StRun   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  typedef struct packed {
    logic [DcrAddrW-1:0] addr;
    logic [DcrDataW-1:0] data;
  } dcr_entry_t;

endpackage

// File: rtl/vx_launch_fifo.sv
// Circular buffer of pending DCR writes with push, pop, flush and occupancy count.
module vx_launch_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 44
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  input  logic                         clear,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wptr_q] <= wdata;
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/vx_launch_ctrl.sv
// Launch sequencer: drains buffered DCR writes while holding the core in reset, then releases
// reset and tracks busy through start, completion, timeout and run-cycle count.
module vx_launch_ctrl
  import vx_launch_pkg::*;
#(
  parameter int unsigned DCR_ADDR_W    = DcrAddrW,
  parameter int unsigned DCR_DATA_W    = DcrDataW,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned RESET_CYCLES  = 8,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned CYC_W         = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DCR_ADDR_W-1:0] cfg_addr,
  input  logic [DCR_DATA_W-1:0] cfg_data,
  input  logic                  cfg_clear,
  input  logic                  start,
  output logic                  idle,
  output logic                  done,
  output logic                  error,
  output logic [CYC_W-1:0]      cycles,
  output logic                  vx_reset,
  output logic                  dcr_wr_valid,
  output logic [DCR_ADDR_W-1:0] dcr_wr_addr,
  output logic [DCR_DATA_W-1:0] dcr_wr_data,
  input  logic                  busy
);

  localparam int unsigned EntW   = DCR_ADDR_W + DCR_DATA_W;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned TmrMax = (START_TIMEOUT > RESET_CYCLES) ? START_TIMEOUT : RESET_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] HoldLast = TmrW'(RESET_CYCLES - 1);
  localparam logic [TmrW-1:0] WaitLast = TmrW'(START_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [TmrW-1:0]  tmr_q, tmr_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             error_q, error_d;
  logic             idle_q, done_q, vx_reset_q, wr_valid_q;
  logic [DCR_ADDR_W-1:0] wr_addr_q;
  logic [DCR_DATA_W-1:0] wr_data_q;

  logic            in_idle, empty, push, pop, clear;
  logic [EntW-1:0] head;
  logic [CntW-1:0] count;

  assign in_idle   = (state_q == StIdle);
  assign empty     = (count == '0);
  assign cfg_ready = in_idle && (count < CntW'(DEPTH)) && !cfg_clear;
  assign push      = cfg_valid && cfg_ready;
  assign clear     = in_idle && cfg_clear;
  // The first entry already leaves on the start edge to hit one-cycle start latency.
  assign pop       = !empty && ((in_idle && start && !cfg_clear) || (state_q == StCfg));

  vx_launch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({cfg_addr, cfg_data}),
    .pop     (pop),
    .clear   (clear),
    .head    (head),
    .count   (count)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    cycles_d = cycles_q;
    error_d  = error_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCfg;
          error_d  = 1'b0;
          cycles_d = '0;
        end
      end
      StCfg: begin
        if (empty) begin
          state_d = StHold;
          tmr_d   = '0;
        end
      end
      StHold: begin
        if (tmr_q == HoldLast) begin
          state_d = StWaitb;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StWaitb: begin
        if (busy) begin
          state_d  = StRun;
          cycles_d = CYC_W'(1);
        end else if (tmr_q == WaitLast) begin
          state_d = StIdle;
          error_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StRun: begin
        if (!busy)                state_d  = StDone;
        else if (cycles_q != '1)  cycles_d = cycles_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      cycles_q   <= '0;
      error_q    <= 1'b0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
      vx_reset_q <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cycles_q   <= cycles_d;
      error_q    <= error_d;
      idle_q     <= (state_d == StIdle);
      done_q     <= (state_d == StDone);
      vx_reset_q <= !((state_d == StWaitb) || (state_d == StRun));
      wr_valid_q <= pop;
      if (pop) {wr_addr_q, wr_data_q} <= head;
    end
  end

  assign idle         = idle_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cycles       = cycles_q;
  assign vx_reset     = vx_reset_q;
  assign dcr_wr_valid = wr_valid_q;
  assign dcr_wr_addr  = wr_addr_q;
  assign dcr_wr_data  = wr_data_q;

endmodule

// File: tb/tb_vx_launch_ctrl.sv
// Directed bench for vx_launch_ctrl: DCR writes are scoreboarded in push order, control
// timing and run counts are compared against bench-side expectations.
`timescale 1ns/1ps
module tb_vx_launch_ctrl;
  import vx_launch_pkg::*;

  localparam int unsigned Depth        = 16;
  localparam int unsigned ResetCycles  = 8;
  localparam int unsigned StartTimeout = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_clear = 1'b0, start = 1'b0, busy = 1'b0;
  logic [DcrAddrW-1:0] cfg_addr = '0;
  logic [DcrDataW-1:0] cfg_data = '0;
  logic cfg_ready, idle, done, error, vx_reset, dcr_wr_valid;
  logic [DcrAddrW-1:0] dcr_wr_addr;
  logic [DcrDataW-1:0] dcr_wr_data;
  logic [63:0] cycles;

  logic s_start = 1'b0, s_busy = 1'b0;
  logic s_cfg_ready, s_idle, s_done, s_error, s_vx_reset, s_wr_valid;
  logic [DcrAddrW-1:0] s_wr_addr;
  logic [DcrDataW-1:0] s_wr_data;
  logic [3:0] s_cycles;

  vx_launch_ctrl #(
    .DEPTH (Depth), .RESET_CYCLES (ResetCycles), .START_TIMEOUT (StartTimeout), .CYC_W (64)
  ) u_dut (
    .clk (clk), .reset_n (reset_n), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
    .cfg_addr (cfg_addr), .cfg_data (cfg_data), .cfg_clear (cfg_clear), .start (start),
    .idle (idle), .done (done), .error (error), .cycles (cycles), .vx_reset (vx_reset),
    .dcr_wr_valid (dcr_wr_valid), .dcr_wr_addr (dcr_wr_addr), .dcr_wr_data (dcr_wr_data),
    .busy (busy)
  );

  vx_launch_ctrl #(
    .DEPTH (4), .RESET_CYCLES (2), .START_TIMEOUT (16), .CYC_W (4)
  ) u_sat (
    .clk (clk), .reset_n (reset_n), .cfg_valid (1'b0), .cfg_ready (s_cfg_ready),
    .cfg_addr ('0), .cfg_data ('0), .cfg_clear (1'b0), .start (s_start),
    .idle (s_idle), .done (s_done), .error (s_error), .cycles (s_cycles),
    .vx_reset (s_vx_reset), .dcr_wr_valid (s_wr_valid), .dcr_wr_addr (s_wr_addr),
    .dcr_wr_data (s_wr_data), .busy (s_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dcr_entry_t exp_q[$];
  dcr_entry_t mon_e;
  int n_pass = 0, n_chk = 0;
  int n_wr = 0, n_done = 0, first_wr_cyc = -1, last_wr_cyc = 0, mcount = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (dcr_wr_valid) begin
        n_wr++;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("dcr_wr_unexpected", dcr_wr_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dcr_wr_addr", dcr_wr_addr, mon_e.addr);
          chk("dcr_wr_data", dcr_wr_data, mon_e.data);
        end
      end
      if (done) n_done++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DcrAddrW-1:0] a, input logic [DcrDataW-1:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    if (mcount < Depth) begin
      exp_q.push_back('{addr: a, data: d});
      mcount++;
    end
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_release(input int limit, output int t);
    int k = 0;
    while (vx_reset !== 1'b0 && k < limit) begin
      step();
      k++;
    end
    chk("vx_reset_release", vx_reset, 1'b0);
    t = cyc;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (idle !== 1'b1 && k < limit) begin
      step();
      k++;
    end
    chk("return_idle", idle, 1'b1);
  endtask

  int s_cyc, t_rel, k;

  initial begin
    step(2);
    chk("rst_vx_reset", vx_reset, 1'b1);
    chk("rst_idle", idle, 1'b1);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_wr_valid", dcr_wr_valid, 1'b0);
    chk("rst_cycles", cycles, 64'd0);
    chk("rst_error", error, 1'b0);
    reset_n = 1'b1;
    step();
    chk("post_rst_idle", idle, 1'b1);

    // Three writes, launch, busy high for 100 cycles.
    push(12'h001, 32'h8000_0000);
    push(12'h002, 32'h0000_0000);
    push(12'h003, 32'h0000_0005);
    start = 1'b1;
    step();
    start = 1'b0;
    s_cyc = cyc;
    mcount = 0;
    wait_release(100, t_rel);
    chk("first_wr_latency", first_wr_cyc, s_cyc);
    chk("n_wr_three", n_wr, 3);
    chk("hold_latency", t_rel - last_wr_cyc, ResetCycles + 1);
    step(3);
    busy = 1'b1;
    step(100);
    busy = 1'b0;
    wait_idle(10);
    chk("done_once", n_done, 1);
    chk("cycles_100", cycles, 64'd100);
    chk("error_clear", error, 1'b0);
    chk("sb_drained_1", exp_q.size(), 0);

    // Overfill: only DEPTH entries accepted, drain wraps the pointers.
    for (int i = 0; i < Depth + 2; i++) begin
      chk("cfg_ready_fill", cfg_ready, (mcount < Depth));
      push(DcrAddrW'(i + 16), $urandom);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    mcount = 0;
    wait_release(100, t_rel);
    chk("n_wr_full", n_wr, 3 + Depth);
    step(2);
    busy = 1'b1;
    step(5);
    busy = 1'b0;
    wait_idle(10);
    chk("cycles_5", cycles, 64'd5);
    chk("sb_drained_2", exp_q.size(), 0);

    // Empty launch, busy never rises.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_release(50, t_rel);
    chk("n_wr_empty", n_wr, 3 + Depth);
    wait_idle(StartTimeout + 20);
    chk("timeout_len", cyc - t_rel, StartTimeout);
    chk("timeout_error", error, 1'b1);
    chk("timeout_vx_reset", vx_reset, 1'b1);
    chk("timeout_no_done", n_done, 2);

    // Clear wins over same-cycle push, then launch issues nothing.
    push(12'h0a0, 32'h1111_1111);
    push(12'h0a1, 32'h2222_2222);
    cfg_valid = 1'b1;
    cfg_clear = 1'b1;
    cfg_addr  = 12'h0a2;
    cfg_data  = 32'h3333_3333;
    #1;
    chk("cfg_ready_clear", cfg_ready, 1'b0);
    step();
    cfg_valid = 1'b0;
    cfg_clear = 1'b0;
    exp_q.delete();
    mcount = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("error_cleared_on_start", error, 1'b0);
    wait_release(50, t_rel);
    chk("n_wr_cleared", n_wr, 3 + Depth);
    step();
    busy = 1'b1;
    step(10);

    // Reset in RUN.
    reset_n = 1'b0;
    #1;
    chk("mid_rst_vx_reset", vx_reset, 1'b1);
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_cycles", cycles, 64'd0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_wr_addr", dcr_wr_addr, 0);
    busy = 1'b0;
    step(2);
    reset_n = 1'b1;
    step();
    chk("post_mid_rst_ready", cfg_ready, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_release(50, t_rel);
    chk("n_wr_after_reset", n_wr, 3 + Depth);
    busy = 1'b1;
    step(2);
    busy = 1'b0;
    wait_idle(10);
    chk("cycles_2", cycles, 64'd2);

    // Saturation with a 4-bit counter; starts during RUN are ignored.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    k = 0;
    while (s_vx_reset !== 1'b0 && k < 40) begin
      step();
      k++;
    end
    chk("sat_release", s_vx_reset, 1'b0);
    s_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_start = (i % 3 == 0);
      step();
    end
    s_start = 1'b0;
    s_busy  = 1'b0;
    k = 0;
    while (s_idle !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    chk("sat_idle", s_idle, 1'b1);
    chk("sat_cycles", s_cycles, 4'hf);
    step(3);
    chk("sat_stays_idle", s_idle, 1'b1);
    chk("sat_error", s_error, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

endmodule
